// File: rtl/bcd_pkg.sv
// Shared types and constants for the two-digit BCD scan counter.
// Digits are plain 4-bit BCD; the run FSM has two states.
package bcd_pkg;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade with load, clear and up/down step.
// Carry/borrow are combinational so the next decade steps in the same cycle.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  bcd_t load_digit,
  input  logic step,
  input  logic up,
  output bcd_t digit,
  output logic carry_out,
  output logic borrow_out
);

  assign carry_out  = step & up & (digit == BCD_MAX);
  assign borrow_out = step & ~up & (digit == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      digit <= 4'd0;
    end else if (clr) begin
      digit <= 4'd0;
    end else if (load) begin
      digit <= load_digit;
    end else if (step) begin
      if (up) begin
        digit <= carry_out ? 4'd0 : digit + 4'd1;
      end else begin
        digit <= borrow_out ? BCD_MAX : digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_scan_counter.sv
// Two-digit BCD up/down counter with run/stop FSM, tick prescaler
// and a free-running digit scan feeding one seven-segment decoder.
module bcd_scan_counter
  import bcd_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       up,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [3:0] data,
  output logic       sel,
  output logic [7:0] count,
  output logic       wrap,
  output logic       load_err
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  state_t        state;
  state_t        state_next;
  logic [TW-1:0] presc;
  logic [SW-1:0] scan;
  logic          tick;
  logic          load_ok;
  logic          step;
  bcd_t          ones;
  bcd_t          tens;
  logic          ones_carry;
  logic          ones_borrow;
  logic          tens_carry;
  logic          tens_borrow;

  assign tick    = (state == RUNNING) && (presc == TICK_LAST);
  assign load_ok = (load_val[7:4] <= BCD_MAX) &&
                   (load_val[3:0] <= BCD_MAX);
  // Any load strobe, accepted or not, swallows a coincident tick.
  assign step    = tick & ~clr & ~load;

  always_comb begin
    state_next = state;
    if (clr) begin
      state_next = STOPPED;
    end else if (start_stop) begin
      state_next = (state == RUNNING) ? STOPPED : RUNNING;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STOPPED;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else if (state == RUNNING && !clr && !load &&
                 !start_stop && !tick) begin
      presc <= presc + TW'(1);
    end else begin
      presc <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan <= '0;
      sel  <= 1'b0;
    end else if (scan == SCAN_LAST) begin
      scan <= '0;
      sel  <= ~sel;
    end else begin
      scan <= scan + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= tens_carry | tens_borrow;
      load_err <= load & ~clr & ~load_ok;
    end
  end

  bcd_digit u_ones (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .load       (load & load_ok),
    .load_digit (load_val[3:0]),
    .step       (step),
    .up         (up),
    .digit      (ones),
    .carry_out  (ones_carry),
    .borrow_out (ones_borrow)
  );

  bcd_digit u_tens (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .load       (load & load_ok),
    .load_digit (load_val[7:4]),
    .step       (ones_carry | ones_borrow),
    .up         (up),
    .digit      (tens),
    .carry_out  (tens_carry),
    .borrow_out (tens_borrow)
  );

  assign count = {tens, ones};
  assign data  = sel ? tens : ones;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Scoreboard bench for bcd_scan_counter: an integer reference model
// predicts every cycle's outputs, a monitor pops and compares them.
module tb_bcd_scan_counter;

  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_stop = 1'b0;
  logic       up = 1'b1;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [3:0] data;
  logic       sel;
  logic [7:0] count;
  logic       wrap;
  logic       load_err;

  always #5 clk = ~clk;

  bcd_scan_counter #(
    .TICK_DIV (TICK_DIV),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_stop (start_stop),
    .up         (up),
    .clr        (clr),
    .load       (load),
    .load_val   (load_val),
    .data       (data),
    .sel        (sel),
    .count      (count),
    .wrap       (wrap),
    .load_err   (load_err)
  );

  typedef struct {
    logic [7:0] count;
    logic       wrap;
    logic       err;
    logic       sel;
    logic [3:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails = 0;

  // reference model state: value as an integer 0..99
  int val = 0;
  int elapsed = 0;
  int scan_t = 0;
  bit running = 1'b0;
  bit sel_m = 1'b0;

  function automatic logic [7:0] bcd_of(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [7:0] got,
                       input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h",
               name, $time, got, exp);
    end
  endtask

  task automatic drive(input bit r, input bit ss, input bit u,
                       input bit c, input bit l,
                       input logic [7:0] lv);
    exp_t e;
    bit   tick_m;
    bit   wrap_m;
    bit   err_m;
    int   hi;
    int   lo;
    @(negedge clk);
    rst = r;
    start_stop = ss;
    up = u;
    clr = c;
    load = l;
    load_val = lv;
    hi = int'(lv[7:4]);
    lo = int'(lv[3:0]);
    wrap_m = 1'b0;
    err_m = 1'b0;
    if (r) begin
      val = 0;
      running = 1'b0;
      elapsed = 0;
      scan_t = 0;
      sel_m = 1'b0;
    end else begin
      tick_m = running && (elapsed == TICK_DIV - 1);
      scan_t++;
      if (scan_t == SCAN_DIV) begin
        scan_t = 0;
        sel_m = !sel_m;
      end
      if (c) begin
        val = 0;
        running = 1'b0;
        elapsed = 0;
      end else if (l) begin
        if (hi <= 9 && lo <= 9) val = hi * 10 + lo;
        else err_m = 1'b1;
        elapsed = 0;
        if (ss) running = !running;
      end else begin
        if (tick_m) begin
          if (u) begin
            wrap_m = (val == 99);
            val = (val + 1) % 100;
          end else begin
            wrap_m = (val == 0);
            val = (val + 99) % 100;
          end
        end
        if (ss) begin
          running = !running;
          elapsed = 0;
        end else if (running) begin
          elapsed = tick_m ? 0 : elapsed + 1;
        end
      end
    end
    e.count = bcd_of(val);
    e.wrap = wrap_m;
    e.err = err_m;
    e.sel = sel_m;
    e.data = sel_m ? 4'(val / 10) : 4'(val % 10);
    sb.push_back(e);
  endtask

  task automatic idle(input int n, input bit u);
    for (int i = 0; i < n; i++) drive(0, 0, u, 0, 0, 8'h00);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("count", count, e.count);
        check("wrap", {7'd0, wrap}, {7'd0, e.wrap});
        check("load_err", {7'd0, load_err}, {7'd0, e.err});
        check("sel", {7'd0, sel}, {7'd0, e.sel});
        check("data", {4'd0, data}, {4'd0, e.data});
      end
    end
  end

  initial begin : stim
    bit u;
    drive(1, 0, 1, 0, 0, 8'h00);
    drive(1, 0, 1, 0, 0, 8'h00);
    // count up from 00 after a start pulse
    drive(0, 1, 1, 0, 0, 8'h00);
    idle(40, 1);
    // wrap up through 99, then down through 00
    drive(0, 0, 1, 0, 1, 8'h98);
    idle(12, 1);
    idle(12, 0);
    // rejected load, then a load colliding with a tick
    drive(0, 0, 1, 0, 1, 8'h3A);
    idle(3, 1);
    for (int k = 0; k < 8 && !(running && elapsed == TICK_DIV - 1); k++)
      idle(1, 1);
    drive(0, 0, 1, 0, 1, 8'h45);
    idle(6, 1);
    // scan of a static 72
    drive(0, running, 1, 0, 0, 8'h00);
    drive(0, 0, 1, 0, 1, 8'h72);
    idle(10, 1);
    // clear together with start_stop while running
    drive(0, 1, 1, 0, 0, 8'h00);
    idle(6, 1);
    drive(0, 1, 1, 1, 0, 8'h00);
    idle(20, 1);
    // reset mid-count with sel on the tens digit
    drive(0, 0, 1, 0, 1, 8'h57);
    drive(0, 1, 1, 0, 0, 8'h00);
    for (int k = 0; k < 4 && !sel_m; k++) idle(1, 1);
    drive(1, 0, 1, 0, 0, 8'h00);
    idle(10, 1);
    // randomized traffic
    u = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 39) == 0) u = !u;
      drive($urandom_range(0, 199) == 0,
            $urandom_range(0, 29) == 0,
            u,
            $urandom_range(0, 99) == 0,
            $urandom_range(0, 24) == 0,
            8'($urandom_range(0, 255)));
    end
    @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/bcd_scan_counter.md
# bcd_scan_counter

Two-digit BCD up/down counter (00–99) with a run/stop control, tick prescaler and time-multiplexed digit output. It sits directly upstream of the single-digit BCD-to-seven-segment decoder. Each scan slot it presents one 4-bit BCD digit on `data` together with a digit-select on `sel`, so one decoder instance drives a two-digit common display.

## Interface
- `TICK_DIV`, 50_000_000: clk cycles per count step (1 Hz at 50 MHz); must be ≥ 2.
- `SCAN_DIV`, 50_000: clk cycles per digit slot (1 kHz scan at 50 MHz); must be ≥ 1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_stop`  in  1  single-cycle pulse; toggles STOPPED/RUNNING.
- `up`  in  1  direction: 1 counts up, 0 counts down; sampled on each tick.
- `clr`  in  1  synchronous clear to 00 and STOPPED.
- `load`  in  1  single-cycle load strobe for `load_val`.
- `load_val`  in  8  BCD value to load: [7:4] is tens, [3:0] is ones.
- `data`  out  4  BCD digit for the downstream decoder.
- `sel`  out  1  digit select: 0 = ones digit, 1 = tens digit.
- `count`  out  8  current BCD count: {tens, ones}.
- `wrap`  out  1  one-cycle pulse on 99→00 (up) or 00→99 (down).
- `load_err`  out  1  one-cycle pulse when a load is rejected.

## Operation
- FSM states:
  - STOPPED: prescaler held at 0, no ticks.
  - RUNNING: prescaler counts 0..TICK_DIV-1. Reaching TICK_DIV-1 produces an internal tick and the prescaler returns to 0.
- Transitions:
  - `start_stop` pulse in STOPPED → RUNNING, with the prescaler starting from 0.
  - `start_stop` pulse in RUNNING → STOPPED, with the prescaler cleared to 0.
- Priority per cycle: `rst` > `clr` > `load` > tick.
  - `clr`: count=00, state=STOPPED, prescaler=0. A `start_stop` in the same cycle is ignored.
  - `load`: count=`load_val` when both nibbles are ≤ 9. Otherwise the count is unchanged and `load_err` pulses. The FSM state is unaffected. The prescaler is cleared to 0 so a full period elapses before the next tick.
  - A load in the same cycle as a tick overrides the tick; no `wrap` is generated.
- Tick stepping (BCD):
  - Up: ones 9→0 with a carry into tens; 99→00 asserts `wrap`.
  - Down: ones 0→9 with a borrow from tens; 00→99 asserts `wrap`.
  - Digits never hold a value above 9.
- Scan: a free-running scan counter, independent of the FSM, counts 0..SCAN_DIV-1. On reaching SCAN_DIV-1, `sel` toggles.
- `data` = `sel` ? tens : ones. `data` is combinational from registered `sel` and count, so it always matches `sel` in the same cycle.
- Reset values: count=00, state=STOPPED, prescaler=0, scan counter=0, `sel`=0, `data`=0, `wrap`=0, `load_err`=0.

## Timing
- A tick on cycle N updates `count` and pulses `wrap` at the edge ending cycle N. Both are visible in cycle N+1.
- RUNNING entered at edge E: first tick occurs TICK_DIV cycles after E. The step period is exactly TICK_DIV cycles.
- Load: `count` updates one cycle after the `load` strobe. `load_err` is visible in the same following cycle.
- `sel` toggles every SCAN_DIV cycles. A count change becomes visible on `data` in the first cycle after the update in which `sel` selects that digit.
- Reset mid-operation: all state is at reset values on the cycle after `rst` is sampled high. Reset dominates every other input.

## Structure
- Shared package `bcd_pkg` holds:
  - FSM state typedef (STOPPED, RUNNING);
  - `BCD_MAX` = 4'd9;
  - 4-bit BCD digit typedef.
- Sub-module `bcd_digit`: one decade.
  - Inputs: clk, rst, clr, load, load_digit, step, up.
  - Outputs: digit, carry_out (9→0 up), borrow_out (0→9 down).
  - Instantiated twice: the ones digit's carry/borrow drives the tens digit's step.
- Top level holds the FSM, prescaler, scan counter, load validation and output mux.

## Test plan
Test parameters: TICK_DIV=4, SCAN_DIV=2.
1. Reset, pulse `start_stop`, `up`=1, run 40 cycles → `count` goes 00,01,…,10; exactly one step every 4 cycles; first step 4 cycles after the pulse.
2. Load 8'h98, run up → 98, 99, then 00 with `wrap` high for exactly 1 cycle; continue down from 00 → 99 with `wrap` pulse.
3. Load 8'h3A → `load_err` pulses 1 cycle and `count` stays unchanged. Load 8'h45 in the same cycle as a tick → `count`=45, no step, no `wrap`.
4. Load 8'h72 → `sel` alternates every 2 cycles; `data`=2 when `sel`=0 and 7 when `sel`=1.
5. In RUNNING, assert `clr` and `start_stop` together → `count`=00, state STOPPED, no further steps over 20 cycles.
6. Assert `rst` mid-count (count=57, RUNNING, `sel`=1) → next cycle: `count`=00, `sel`=0, `data`=0, `wrap`=0, no steps until `start_stop`.
